// File: rtl/oddeven_stream_sorter.sv
// Streaming frame sorter: loads up to DEPTH beats, sorts them in place with
// odd-even transposition (one phase per clock, early exit), then streams them out.

module oes_cmp_pair #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             i_en,
  input  logic             i_desc,
  input  logic             i_lo_vld,
  input  logic             i_hi_vld,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  output logic             o_swap
);
  logic w_gt, w_lt;

  generate
    if (SIGNED != 0) begin : g_signed
      assign w_gt = $signed(i_lo) > $signed(i_hi);
      assign w_lt = $signed(i_lo) < $signed(i_hi);
    end else begin : g_unsigned
      assign w_gt = i_lo > i_hi;
      assign w_lt = i_lo < i_hi;
    end
  endgenerate

  // An empty slot ranks after any valid one, so it always sinks upward.
  always_comb begin
    o_swap = 1'b0;
    if (i_en) begin
      if (!i_lo_vld)     o_swap = i_hi_vld;
      else if (i_hi_vld) o_swap = i_desc ? w_lt : w_gt;
    end
  end
endmodule

module oddeven_stream_sorter #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             descending,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CW-1:0]    sort_cycles
);
  typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

  state_t                      r_state, w_state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] r_data, w_srt_data;
  logic [DEPTH-1:0]            r_vld, w_srt_vld;
  logic [DEPTH-2:0]            w_swap;
  logic [CW-1:0]               r_n, r_phase, r_rd, r_sort_cycles;
  logic [CW-1:0]               w_n_inc, w_phase_inc, w_rd_inc;
  logic                        r_desc, r_prev_quiet, r_in_ready;
  logic                        r_out_valid, r_out_last;
  logic [WIDTH-1:0]            r_out_data, w_rd_data;
  logic                        w_accept, w_load_done, w_any_swap, w_sort_done, w_out_acc;

  assign w_n_inc     = r_n + CW'(1);
  assign w_phase_inc = r_phase + CW'(1);
  assign w_rd_inc    = r_rd + CW'(1);
  assign w_accept    = (r_state == LOAD) && in_valid && r_in_ready;
  assign w_load_done = w_accept && (in_last || (w_n_inc == CW'(DEPTH)));
  assign w_any_swap  = |w_swap;
  assign w_sort_done = (r_state == SORT) &&
                       ((!w_any_swap && r_prev_quiet) || (w_phase_inc == CW'(DEPTH)));
  assign w_out_acc   = (r_state == UNLOAD) && r_out_valid && out_ready;

  genvar i, j;
  generate
    for (i = 0; i < DEPTH - 1; i++) begin : g_pair
      localparam logic PAR = (i % 2) == 1;
      oes_cmp_pair #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_pair (
        .i_en     (r_state == SORT && r_phase[0] == PAR),
        .i_desc   (r_desc),
        .i_lo_vld (r_vld[i]),
        .i_hi_vld (r_vld[i+1]),
        .i_lo     (r_data[i]),
        .i_hi     (r_data[i+1]),
        .o_swap   (w_swap[i])
      );
    end

    for (j = 0; j < DEPTH; j++) begin : g_slot
      if (j == 0) begin : g_first
        assign w_srt_data[j] = w_swap[j] ? r_data[j+1] : r_data[j];
        assign w_srt_vld[j]  = w_swap[j] ? r_vld[j+1]  : r_vld[j];
      end else if (j == DEPTH - 1) begin : g_final
        assign w_srt_data[j] = w_swap[j-1] ? r_data[j-1] : r_data[j];
        assign w_srt_vld[j]  = w_swap[j-1] ? r_vld[j-1]  : r_vld[j];
      end else begin : g_mid
        assign w_srt_data[j] = w_swap[j] ? r_data[j+1] : w_swap[j-1] ? r_data[j-1] : r_data[j];
        assign w_srt_vld[j]  = w_swap[j] ? r_vld[j+1]  : w_swap[j-1] ? r_vld[j-1]  : r_vld[j];
      end
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) == w_rd_inc) w_rd_data = r_data[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_load_done) w_state_nxt = SORT;
      SORT:    if (w_sort_done) w_state_nxt = UNLOAD;
      UNLOAD:  if (w_out_acc && r_out_last) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data        <= '0;
      r_vld         <= '0;
      r_n           <= '0;
      r_phase       <= '0;
      r_rd          <= '0;
      r_sort_cycles <= '0;
      r_desc        <= 1'b0;
      r_prev_quiet  <= 1'b0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == LOAD);
      case (r_state)
        LOAD: if (w_accept) begin
          for (int k = 0; k < DEPTH; k++)
            if (CW'(k) == r_n) begin
              r_data[k] <= in_data;
              r_vld[k]  <= 1'b1;
            end
          r_n <= w_n_inc;
          if (r_n == '0) r_desc <= descending;
          r_phase      <= '0;
          r_prev_quiet <= 1'b0;
        end
        SORT: begin
          r_data       <= w_srt_data;
          r_vld        <= w_srt_vld;
          r_phase      <= w_phase_inc;
          r_prev_quiet <= !w_any_swap;
          // Present slot 0 straight from the final phase so UNLOAD starts valid.
          if (w_sort_done) begin
            r_sort_cycles <= w_phase_inc;
            r_out_valid   <= 1'b1;
            r_out_data    <= w_srt_data[0];
            r_out_last    <= (r_n == CW'(1));
            r_rd          <= '0;
          end
        end
        UNLOAD: if (w_out_acc) begin
          if (r_out_last) begin
            r_n          <= '0;
            r_vld        <= '0;
            r_phase      <= '0;
            r_rd         <= '0;
            r_prev_quiet <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
          end else begin
            r_rd       <= w_rd_inc;
            r_out_data <= w_rd_data;
            r_out_last <= (w_rd_inc == r_n - CW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = (r_state != LOAD);
  assign sort_cycles = r_sort_cycles;
endmodule
